// File: rtl/barrel_ctrl.sv
// ============================================================================
// barrel_ctrl : rolling/falling barrel position and animation controller.
// Optional feature macro: BARREL_CTRL_KILL_EN (adds the kill input).
// Revision: 1.0
// ============================================================================
`default_nettype none

module barrel_ctrl #(
  parameter int SPAWN_X    = 100,
  parameter int SPAWN_Y    = 60,
  parameter int LEFT_EDGE  = 40,
  parameter int RIGHT_EDGE = 600,
  parameter int PITCH      = 80,
  parameter int FLOOR_Y    = 380,
  parameter int ROLL_STEP  = 2,
  parameter int FALL_STEP  = 4,
  parameter int ANIM_DIV   = 4
) (
  input  logic       clk,
  input  logic       rst,
`ifdef BARREL_CTRL_KILL_EN
  input  logic       kill,
`endif
  input  logic       frame_tick,
  input  logic       spawn,
  output logic [9:0] posX,
  output logic [8:0] posY,
  output logic [1:0] state,
  output logic [2:0] animation_state,
  output logic       done
);

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic [9:0]    C_SPAWN_X  = 10'(SPAWN_X);
  localparam logic [8:0]    C_SPAWN_Y  = 9'(SPAWN_Y);
  localparam logic [10:0]   C_LEFT     = 11'(LEFT_EDGE);
  localparam logic [10:0]   C_RIGHT    = 11'(RIGHT_EDGE);
  localparam logic [10:0]   C_ROLL     = 11'(ROLL_STEP);
  localparam logic [9:0]    C_FALL     = 10'(FALL_STEP);
  localparam logic [9:0]    C_PITCH    = 10'(PITCH);
  localparam logic [8:0]    C_FLOOR    = 9'(FLOOR_Y);
  localparam logic [CW-1:0] C_CNT_MAX  = CW'(ANIM_DIV - 1);

  localparam logic [2:0] C_ROLL1 = 3'b000;
  localparam logic [2:0] C_FALL1 = 3'b100;

  typedef enum logic [1:0] {
    S_INITIAL = 2'b00,
    S_ROLLING = 2'b01,
    S_FALLING = 2'b10
  } state_t;

  state_t        r_state;
  logic          r_dir;      // 0 = moving right, 1 = moving left
  logic [CW-1:0] r_cnt;
  logic [8:0]    r_target;

  logic          w_kill;
`ifdef BARREL_CTRL_KILL_EN
  assign w_kill = kill;
`else
  assign w_kill = 1'b0;
`endif

  // Horizontal motion, computed one bit wider so the edge tests cannot wrap
  logic [10:0] w_x_plus;
  logic [9:0]  w_x_minus;
  logic        w_right_hit;
  logic        w_left_hit;
  logic        w_edge;
  logic [9:0]  w_x_next;

  assign w_x_plus    = {1'b0, posX} + C_ROLL;
  assign w_x_minus   = posX - C_ROLL[9:0];
  assign w_right_hit = (w_x_plus >= C_RIGHT);
  assign w_left_hit  = ({1'b0, posX} <= (C_LEFT + C_ROLL));
  assign w_edge      = r_dir ? w_left_hit : w_right_hit;
  assign w_x_next    = w_edge ? (r_dir ? C_LEFT[9:0] : C_RIGHT[9:0])
                              : (r_dir ? w_x_minus : w_x_plus[9:0]);

  logic [9:0] w_y_plus;
  logic       w_land;
  logic [9:0] w_target_sum;
  logic       w_above_floor;

  assign w_y_plus      = {1'b0, posY} + C_FALL;
  assign w_land        = (w_y_plus >= {1'b0, r_target});
  assign w_target_sum  = {1'b0, posY} + C_PITCH;
  assign w_above_floor = (posY < C_FLOOR);

  logic          w_wrap;
  logic [CW-1:0] w_cnt_next;
  logic [2:0]    w_roll_anim;

  assign w_wrap      = (r_cnt == C_CNT_MAX);
  assign w_cnt_next  = w_wrap ? '0 : r_cnt + 1'b1;
  assign w_roll_anim = r_dir ? {1'b0, animation_state[1:0] - 2'd1}
                             : {1'b0, animation_state[1:0] + 2'd1};

  assign state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_INITIAL;
      posX            <= C_SPAWN_X;
      posY            <= C_SPAWN_Y;
      animation_state <= C_ROLL1;
      r_dir           <= 1'b0;
      r_cnt           <= '0;
      r_target        <= '0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_INITIAL: begin
          if (spawn) begin
            posX            <= C_SPAWN_X;
            posY            <= C_SPAWN_Y;
            r_dir           <= 1'b0;
            animation_state <= C_ROLL1;
            r_cnt           <= '0;
            r_state         <= S_ROLLING;
          end
        end

        S_ROLLING: begin
          if (w_kill) begin
            r_state <= S_INITIAL;
            done    <= 1'b1;
          end else if (frame_tick) begin
            posX <= w_x_next;
            if (w_edge) begin
              // Edge event owns the animation; any pending wrap is dropped
              if (w_above_floor) begin
                r_target        <= w_target_sum[8:0];
                animation_state <= C_FALL1;
                r_cnt           <= '0;
                r_state         <= S_FALLING;
              end else begin
                r_state <= S_INITIAL;
                done    <= 1'b1;
              end
            end else begin
              r_cnt <= w_cnt_next;
              if (w_wrap) begin
                animation_state <= w_roll_anim;
              end
            end
          end
        end

        S_FALLING: begin
          if (w_kill) begin
            r_state <= S_INITIAL;
            done    <= 1'b1;
          end else if (frame_tick) begin
            if (w_land) begin
              posY            <= r_target;
              r_dir           <= ~r_dir;
              animation_state <= C_ROLL1;
              r_cnt           <= '0;
              r_state         <= S_ROLLING;
            end else begin
              posY  <= w_y_plus[8:0];
              r_cnt <= w_cnt_next;
              if (w_wrap) begin
                animation_state <= animation_state ^ 3'b001;
              end
            end
          end
        end

        default: begin
          r_state <= S_INITIAL;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_barrel_ctrl.sv
// ============================================================================
// tb_barrel_ctrl : directed self-checking bench for barrel_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_barrel_ctrl;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       spawn;
  logic       kill;
  logic [9:0] posX;
  logic [8:0] posY;
  logic [1:0] state;
  logic [2:0] animation_state;
  logic       done;

  int n_checks;
  int n_fail;

  barrel_ctrl dut (
    .clk             (clk),
    .rst             (rst),
`ifdef BARREL_CTRL_KILL_EN
    .kill            (kill),
`endif
    .frame_tick      (frame_tick),
    .spawn           (spawn),
    .posX            (posX),
    .posY            (posY),
    .state           (state),
    .animation_state (animation_state),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges; outputs are then sampled 1ns after the last edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cycles;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    frame_tick = 1'b1;
    spawn      = 1'b1;
    kill       = 1'b0;
    step(2);
    check("rst_state", state, 0);
    check("rst_posX", posX, 100);
    check("rst_posY", posY, 60);
    check("rst_anim", animation_state, 0);
    check("rst_done", done, 0);

    rst        = 1'b0;
    frame_tick = 1'b0;
    step(1);
    spawn = 1'b0;
    check("spawn_state", state, 1);
    check("spawn_posX", posX, 100);
    check("spawn_posY", posY, 60);
    check("spawn_anim", animation_state, 0);

    frame_tick = 1'b1;
    step(4);
    check("roll4_posX", posX, 108);
    check("roll4_anim_right", animation_state, 1);
    step(245);
    check("roll249_posX", posX, 598);
    check("roll249_state", state, 1);
    step(1);
    check("right_edge_posX", posX, 600);
    check("right_edge_state", state, 2);
    check("right_edge_anim", animation_state, 4);
    check("right_edge_posY", posY, 60);

    step(4);
    check("fall4_posY", posY, 76);
    check("fall4_anim", animation_state, 5);
    step(15);
    check("fall19_posY", posY, 136);
    check("fall19_state", state, 2);
    step(1);
    check("land_posY", posY, 140);
    check("land_state", state, 1);
    check("land_anim_priority", animation_state, 0);
    step(1);
    check("left_roll_posX", posX, 598);
    step(3);
    check("left_roll_posX4", posX, 592);
    check("roll4_anim_left", animation_state, 3);

    spawn = 1'b1;
    step(1);
    spawn = 1'b0;
    check("spawn_ignored_posX", posX, 590);
    check("spawn_ignored_state", state, 1);
    frame_tick = 1'b0;
    step(1);
    check("no_tick_hold_posX", posX, 590);

    // Ride the remaining rows down to the floor, bounded in cycles
    frame_tick = 1'b1;
    cycles = 0;
    while (cycles < 2000) begin
      step(1);
      cycles++;
      if (done) break;
    end
    check("floor_done_seen", done, 1);
    check("floor_tick_count", cycles, 1175);
    check("floor_state", state, 0);
    check("floor_posY", posY, 380);
    check("floor_posX", posX, 600);

    spawn = 1'b1;
    step(1);
    spawn = 1'b0;
    check("done_one_cycle", done, 0);
    check("relaunch_state", state, 1);
    check("relaunch_posX", posX, 100);
    check("relaunch_posY", posY, 60);

    step(260);
    check("midfall_posY", posY, 100);
    check("midfall_state", state, 2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midfall_rst_state", state, 0);
    check("midfall_rst_posY", posY, 60);
    check("midfall_rst_posX", posX, 100);
    check("midfall_rst_anim", animation_state, 0);
    check("midfall_rst_done", done, 0);
    step(1);
    check("initial_tick_ignored_posX", posX, 100);
    check("initial_tick_ignored_state", state, 0);

    frame_tick = 1'b0;
    spawn      = 1'b1;
    step(1);
    spawn      = 1'b0;
    frame_tick = 1'b1;
    step(1);
    check("post_rst_dir_right", posX, 102);

`ifdef BARREL_CTRL_KILL_EN
    step(3);
    kill = 1'b1;
    step(1);
    kill = 1'b0;
    check("kill_state", state, 0);
    check("kill_done", done, 1);
    step(1);
    check("kill_done_pulse", done, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/barrel_ctrl.md
BARREL_CTRL -- requirements
Module: barrel_ctrl

Interface
REQ-001 Parameters SHALL be SPAWN_X, default 100, spawn column (pixel); SPAWN_Y, default 60, spawn row and top platform.
REQ-002 Parameters SHALL be LEFT_EDGE, default 40, and RIGHT_EDGE, default 600, the platform ends in pixels.
REQ-003 Parameters SHALL be PITCH, default 80, row distance between platforms; FLOOR_Y, default 380, bottom platform row.
REQ-004 Parameters SHALL be ROLL_STEP, default 2, px per tick; FALL_STEP, default 4, px per tick; ANIM_DIV, default 4, ticks per animation frame.
REQ-005 Port clk, input, 1, the only clock; all logic SHALL use its rising edge.
REQ-006 Port rst, input, 1, reset; it SHALL be synchronous and active-high.
REQ-007 Port frame_tick, input, 1, one-cycle pulse once per video frame.
REQ-008 Port spawn, input, 1, request to launch a barrel.
REQ-009 Port posX, output, 10, barrel centre column; posY, output, 9, barrel centre row.
REQ-010 Port state, output, 2, encoded 00 INITIAL, 01 ROLLING, 10 FALLING; 11 SHALL never be driven.
REQ-011 Port animation_state, output, 3, encoded 000-011 ROLL1-ROLL4, 100 FALL1, 101 FALL2.
REQ-012 Port done, output, 1, one-cycle pulse when the barrel retires.

Function
REQ-013 All outputs SHALL be registered and SHALL change only on clk edges.
REQ-014 In INITIAL, spawn=1 SHALL load posX=SPAWN_X, posY=SPAWN_Y, dir=right, animation_state=ROLL1, anim counter=0, and enter ROLLING next cycle.
REQ-015 If spawn and frame_tick are both asserted in INITIAL, spawn SHALL take effect and no motion SHALL occur that cycle.
REQ-016 spawn SHALL be ignored outside INITIAL; frame_tick SHALL be ignored in INITIAL.
REQ-017 In ROLLING, each frame_tick SHALL move posX by ROLL_STEP: add when dir=right, subtract when dir=left.
REQ-018 If the new posX reaches or passes an edge (>=RIGHT_EDGE moving right, <=LEFT_EDGE moving left), posX SHALL be clamped to that edge; there SHALL be no wrap-around.
REQ-019 At an edge, if posY<FLOOR_Y, the block SHALL latch target=posY+PITCH, enter FALLING, set animation_state=FALL1 and clear the anim counter.
REQ-020 At an edge, if posY>=FLOOR_Y, the block SHALL enter INITIAL and pulse done for exactly one cycle.
REQ-021 In FALLING, each frame_tick SHALL add FALL_STEP to posY; on reaching or passing target, posY SHALL clamp to target, dir SHALL toggle, animation_state SHALL become ROLL1, the anim counter SHALL clear, and state SHALL become ROLLING.
REQ-022 The anim counter SHALL count frame_ticks in ROLLING/FALLING and wrap at ANIM_DIV-1; on wrap, ROLLING SHALL step ROLL1..ROLL4 (+1 mod 4 when dir=right, -1 mod 4 when dir=left), and FALLING SHALL alternate FALL1/FALL2.
REQ-023 If an edge or landing event coincides with an anim wrap, the event's animation assignment SHALL take priority.
REQ-024 Arithmetic SHALL be unsigned; posX/posY SHALL never exceed 639/479 for legal parameters.

Reset
REQ-025 rst=1 SHALL force state=INITIAL, posX=SPAWN_X, posY=SPAWN_Y, animation_state=ROLL1, dir=right, anim counter=0, target=0 and done=0 on the next edge, overriding every other input, including when asserted mid-roll or mid-fall.

Configuration
REQ-026 With macro BARREL_CTRL_KILL_EN defined, a 1-bit input kill SHALL exist; kill=1 in ROLLING or FALLING SHALL force INITIAL and pulse done for one cycle, with priority below rst and above frame_tick.
REQ-027 Without BARREL_CTRL_KILL_EN, the kill port SHALL be absent, and a barrel SHALL leave ROLLING/FALLING only through REQ-020 or reset.

Verification
REQ-028 Scenario: rst, then spawn -> state=01, posX=100, posY=60, animation_state=000 one cycle later.
REQ-029 Scenario: 250 ticks after spawn -> posX=600, state=10, animation_state=100; 20 further ticks -> posY=140, state=01, dir=left.
REQ-030 Scenario: 4 ticks right -> animation_state 000->001; 4 ticks on the left-moving row -> 000->011.
REQ-031 Scenario: run to the floor (posY=380) and reach an edge -> done high exactly 1 cycle, state=00; a tick-coincident spawn at that time -> relaunch with no motion.
REQ-032 Scenario: rst mid-fall at posY=100 -> next cycle state=00, posY=60; with BARREL_CTRL_KILL_EN, kill mid-roll -> state=00, done pulse.
